reg_snapshot_tx: RTL and testbench
==================================

# reg_snapshot_tx

Debug readout engine for the CPU register file. On request it captures the architectural and temporary registers (A, F, B, C, D, E, H, L, SP, PC, W, Z) in one cycle, then streams them out as a fixed byte frame over a valid/ready link. It sits beside the register and bus block as the read side of the register file, and feeds a debug UART or a JTAG shifter. It never drives the CPU buses.

## Interface
Parameters:
- `HDR`, default 8'hA5: frame header byte.

Ports:
- `CLK` input 1: single clock; all state changes on the rising edge.
- `nRES` input 1: asynchronous, active-low reset.
- `req` input 1: snapshot request, sampled only in IDLE.
- `abort` input 1: synchronous cancel of the current frame.
- `rA`, `rF`, `rB`, `rC`, `rD`, `rE`, `rH`, `rL`, `rW`, `rZ` input 8 each: live register values (true polarity).
- `rSP`, `rPC` input 16 each: stack pointer and program counter.
- `tx_data` output 8: current frame byte.
- `tx_valid` output 1: `tx_data` is valid.
- `tx_ready` input 1: sink accepts the byte when `tx_valid & tx_ready`.
- `busy` output 1: frame in progress.
- `done` output 1: one-cycle pulse after the final byte is accepted.
- `ovr` output 1: sticky flag; a request arrived while busy.

## Operation
- States are IDLE and SEND.
- **IDLE → SEND** on `req=1`. At that edge the 14 data bytes are latched into a 112-bit snapshot buffer, the index is cleared to 0 and `ovr` is cleared.
- **Frame order** (index, byte):
  - 0: `HDR`
  - 1–8: A, F, B, C, D, E, H, L
  - 9–10: SP[15:8], SP[7:0]
  - 11–12: PC[15:8], PC[7:0]
  - 13–14: W, Z
  - 15: checksum, the XOR of indices 1–14 (present only with checksum enabled).
- **Byte output:** `tx_data` is a mux of index over the buffer. Live inputs changing during SEND have no effect on the frame.
- **Index advance:** the index increments only on a handshake.
- **SEND → IDLE:**
  - on the handshake of the last index (15, or 14 without checksum);
  - `done` is 1 in the following cycle.
- **`abort=1` in SEND:**
  - the next state is IDLE and the index is cleared;
  - a coincident handshake is not counted;
  - `done` stays 0;
  - `abort` in IDLE has no effect.
- **`req=1` while in SEND,** including the cycle of the last handshake: the request is dropped and `ovr` is set. `ovr` holds until the next accepted request.
- **`req` and `abort` together in IDLE:** the request is accepted.
- **Reset values** (asynchronous, any state):
  - state IDLE, index 0;
  - `tx_valid=0`, `busy=0`, `done=0`, `ovr=0`;
  - `tx_data=8'h00`, buffer all zero.
- **Reset mid-frame:** the partial frame is lost; no `done`.

## Timing
- `req` sampled at edge N gives `tx_valid=1` with `tx_data=HDR` in cycle N+1.
- `busy == tx_valid == (state==SEND)`. All outputs are registered or decoded from registers; there is no combinational path from `tx_ready` to `tx_data`.
- While `tx_valid=1 & tx_ready=0`, `tx_data` holds stable indefinitely.
- With `tx_ready` tied to 1:
  - one byte per cycle;
  - the frame occupies cycles N+1 through N+16 (N+15 without checksum);
  - `done` in cycle N+17 (N+16 without checksum).
- In the `done` cycle the state is IDLE. A `req` in that cycle is accepted, so back-to-back frames are separated by exactly one idle cycle.

## Configuration
- `SNAPSHOT_CHECKSUM_EN` defined:
  - the frame is 16 bytes and the last index is 15;
  - the checksum is accumulated at capture time into an 8-bit register.
- `SNAPSHOT_CHECKSUM_EN` undefined:
  - the frame is 15 bytes and the last index is 14;
  - no checksum logic is present;
  - all other behaviour is identical.

## Test plan
- **Boot-state frame** (checksum on):
  - Stimulus: A=01, F=B0, B=00, C=13, D=00, E=D8, H=01, L=4D, SP=FFFE, PC=0100, W=00, Z=00, `tx_ready=1`, one-cycle `req`.
  - Response: the bytes A5 01 B0 00 13 00 D8 01 4D FF FE 01 00 00 00 36 on consecutive cycles, then `done` for one cycle.
- **Backpressure:**
  - Stimulus: `tx_ready=0` for 5 cycles at index 3, and inputs changed during SEND.
  - Response: `tx_data` holds 00 (B) throughout; the frame still carries the captured values; the total frame is unchanged.
- **Overrun:**
  - Stimulus: `req` pulsed at index 7, and again in the last-handshake cycle.
  - Response: no restart; `ovr=1` after the first overrun pulse; `ovr` clears on the next IDLE `req`.
- **Abort:**
  - Stimulus: `abort` with a coincident handshake at index 9.
  - Response: `tx_valid=0` next cycle, no `done`. A new `req` restarts from `HDR`.
- **Async reset:**
  - Stimulus: `nRES` low mid-clock at index 12.
  - Response: outputs go to their reset values immediately, without waiting for an edge. After release and a `req`, a full frame is produced.
- **Checksum compiled out:**
  - Stimulus: the boot-state frame with `SNAPSHOT_CHECKSUM_EN` undefined.
  - Response: a 15-byte frame ending in Z=00, with `done` in cycle N+16.

Source files
------------

// File: rtl/reg_snapshot_tx_if.sv
// Byte stream link from reg_snapshot_tx to its sink (debug UART or JTAG shifter).
interface reg_snapshot_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/reg_snapshot_tx.sv
// Register-file snapshot engine: captures all registers in one cycle and streams them as a byte frame.
// Define SNAPSHOT_CHECKSUM_EN to append an XOR checksum byte (16-byte frame instead of 15).
module reg_snapshot_tx #(
  parameter logic [7:0] HDR = 8'hA5
) (
  input  logic              CLK,
  input  logic              nRES,
  input  logic              req,
  input  logic              abort,
  input  logic [7:0]        rA,
  input  logic [7:0]        rF,
  input  logic [7:0]        rB,
  input  logic [7:0]        rC,
  input  logic [7:0]        rD,
  input  logic [7:0]        rE,
  input  logic [7:0]        rH,
  input  logic [7:0]        rL,
  input  logic [7:0]        rW,
  input  logic [7:0]        rZ,
  input  logic [15:0]       rSP,
  input  logic [15:0]       rPC,
  reg_snapshot_tx_if.master tx,
  output logic              busy,
  output logic              done,
  output logic              ovr
);

`ifdef SNAPSHOT_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd15;
`else
  localparam logic [3:0] LAST_IDX = 4'd14;
`endif

  typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [13:0][7:0] snap_q, snap_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;
  logic             hs_s;
  logic [7:0]       byte_s;

`ifdef SNAPSHOT_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  function automatic logic [7:0] xor_fold(input logic [13:0][7:0] bytes);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < 14; i++) begin
      acc = acc ^ bytes[i];
    end
    return acc;
  endfunction
`endif

  assign hs_s = (state_q == SEND) && tx.tx_ready;

  // Next-state, index, capture and flag logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
`ifdef SNAPSHOT_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = SEND;
          idx_d   = 4'd0;
          ovr_d   = 1'b0;
          // Element 0 is the first register byte on the wire (A)
          snap_d  = {rZ, rW, rPC[7:0], rPC[15:8], rSP[7:0], rSP[15:8],
                     rL, rH, rE, rD, rC, rB, rF, rA};
`ifdef SNAPSHOT_CHECKSUM_EN
          csum_d  = xor_fold(snap_d);
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (req) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_q;
        end
        // Abort wins over a coincident handshake and suppresses done
        if (abort) begin
          state_d = IDLE;
          idx_d   = 4'd0;
        end else if (hs_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // Frame byte selected by the index; zero outside a frame
  always_comb begin
    byte_s = 8'h00;
    if (state_q == SEND) begin
      case (idx_q)
        4'd0:    byte_s = HDR;
        4'd1:    byte_s = snap_q[0];
        4'd2:    byte_s = snap_q[1];
        4'd3:    byte_s = snap_q[2];
        4'd4:    byte_s = snap_q[3];
        4'd5:    byte_s = snap_q[4];
        4'd6:    byte_s = snap_q[5];
        4'd7:    byte_s = snap_q[6];
        4'd8:    byte_s = snap_q[7];
        4'd9:    byte_s = snap_q[8];
        4'd10:   byte_s = snap_q[9];
        4'd11:   byte_s = snap_q[10];
        4'd12:   byte_s = snap_q[11];
        4'd13:   byte_s = snap_q[12];
        4'd14:   byte_s = snap_q[13];
`ifdef SNAPSHOT_CHECKSUM_EN
        4'd15:   byte_s = csum_q;
`endif
        default: byte_s = 8'h00;
      endcase
    end else begin
      byte_s = 8'h00;
    end
  end

  // State registers
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state_q <= IDLE;
      idx_q   <= 4'd0;
      snap_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef SNAPSHOT_CHECKSUM_EN
      csum_q  <= 8'h00;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
`ifdef SNAPSHOT_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign tx.tx_data  = byte_s;
  assign tx.tx_valid = (state_q == SEND);
  assign busy        = (state_q == SEND);
  assign done        = done_q;
  assign ovr         = ovr_q;

endmodule

// File: tb/tb_reg_snapshot_tx.sv
// Scoreboard bench for reg_snapshot_tx: expected frame bytes are queued at request time
// and popped by a monitor on every handshake.
module tb_reg_snapshot_tx;

`ifdef SNAPSHOT_CHECKSUM_EN
  localparam int NB = 16;
`else
  localparam int NB = 15;
`endif

  logic        CLK, nRES, req, abort;
  logic [7:0]  rA, rF, rB, rC, rD, rE, rH, rL, rW, rZ;
  logic [15:0] rSP, rPC;
  logic        busy, done, ovr;

  reg_snapshot_tx_if bus ();

  reg_snapshot_tx dut (
    .CLK(CLK), .nRES(nRES), .req(req), .abort(abort),
    .rA(rA), .rF(rF), .rB(rB), .rC(rC), .rD(rD), .rE(rE), .rH(rH), .rL(rL),
    .rW(rW), .rZ(rZ), .rSP(rSP), .rPC(rPC),
    .tx(bus.master), .busy(busy), .done(done), .ovr(ovr)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int done_at = 0;
  int c_start = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every wire-level handshake must match the next queued byte
  always @(negedge CLK) begin
    cyc_cnt++;
    if (done) begin
      done_cnt++;
      done_at = cyc_cnt;
    end
    if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got byte %02h, expected no byte", bus.tx_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.tx_data !== mon_exp) begin
          errors++;
          $display("FAIL sb_byte: got %02h, expected %02h", bus.tx_data, mon_exp);
        end
      end
    end
  end

  task automatic set_regs(input logic [7:0] a, f, b, c, d, e, h, l,
                          input logic [15:0] sp, pc, input logic [7:0] w, z);
    rA = a; rF = f; rB = b; rC = c; rD = d; rE = e; rH = h; rL = l;
    rSP = sp; rPC = pc; rW = w; rZ = z;
  endtask

  task automatic set_rand_regs();
    set_regs(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
             16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
  endtask

  // Reference frame built from the current register inputs
  function automatic void push_frame();
    logic [7:0] b[14];
    logic [7:0] cs;
    cs = 8'h00;
    b = '{rA, rF, rB, rC, rD, rE, rH, rL, rSP[15:8], rSP[7:0],
          rPC[15:8], rPC[7:0], rW, rZ};
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 14; i++) begin
      exp_q.push_back(b[i]);
      cs = cs ^ b[i];
    end
`ifdef SNAPSHOT_CHECKSUM_EN
    exp_q.push_back(cs);
`endif
  endfunction

  task automatic pulse_req();
    @(posedge CLK); #1 req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    c_start = cyc_cnt;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    int d0;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge CLK); #1;
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b, expected 0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, expected 0", done); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL rst_ovr: got %b, expected 0", ovr); end
    checks++; if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %02h, expected 00", bus.tx_data); end
    @(negedge CLK) nRES = 1'b1;
    @(posedge CLK); #1;
  endtask

  task automatic test_boot_frame();
    logic [7:0] tab[16];
    bit ok;
    tab = '{8'hA5, 8'h01, 8'hB0, 8'h00, 8'h13, 8'h00, 8'hD8, 8'h01,
            8'h4D, 8'hFF, 8'hFE, 8'h01, 8'h00, 8'h00, 8'h00, 8'h36};
    set_regs(8'h01, 8'hB0, 8'h00, 8'h13, 8'h00, 8'hD8, 8'h01, 8'h4D,
             16'hFFFE, 16'h0100, 8'h00, 8'h00);
    for (int i = 0; i < NB; i++) exp_q.push_back(tab[i]);
    pulse_req();
    @(negedge CLK);
    checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'hA5) begin errors++; $display("FAIL boot_first: got valid=%b data=%02h, expected valid=1 data=a5", bus.tx_valid, bus.tx_data); end
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL boot_timeout: got no done, expected done"); end
    checks++; if (done_at - c_start !== NB + 1) begin errors++; $display("FAIL boot_done_cycle: got N+%0d, expected N+%0d", done_at - c_start, NB + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boot_busy_in_done: got %b, expected 0", busy); end
    @(negedge CLK); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL boot_done_pulse: got %b, expected 0", done); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL boot_leftover: got %0d bytes left, expected 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [7:0] cap_b;
    bit ok;
    set_rand_regs();
    cap_b = rB;
    push_frame();
    pulse_req();
    repeat (3) @(posedge CLK);
    #1 bus.tx_ready = 1'b0;
    set_rand_regs();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++; if (bus.tx_valid !== 1'b1 || bus.tx_data !== cap_b) begin errors++; $display("FAIL bp_hold%0d: got valid=%b data=%02h, expected valid=1 data=%02h", i, bus.tx_valid, bus.tx_data, cap_b); end
    end
    @(posedge CLK); #1 bus.tx_ready = 1'b1;
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no done, expected done"); end
    checks++; if (done_at - c_start !== NB + 6) begin errors++; $display("FAIL bp_done_cycle: got N+%0d, expected N+%0d", done_at - c_start, NB + 6); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover: got %0d, expected 0", exp_q.size()); end
  endtask

  task automatic test_overrun();
    bit ok;
    set_rand_regs();
    push_frame();
    pulse_req();
    repeat (7) @(posedge CLK);
    #1 req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK);
    checks++; if (ovr !== 1'b1 || bus.tx_valid !== 1'b1) begin errors++; $display("FAIL ovr_set: got ovr=%b valid=%b, expected 1 1", ovr, bus.tx_valid); end
    repeat (NB - 9) @(posedge CLK);
    #1 req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    @(negedge CLK);
    checks++; if (done !== 1'b1 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL ovr_last: got done=%b valid=%b, expected 1 0", done, bus.tx_valid); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL ovr_hold: got %b, expected 1", ovr); end
    @(negedge CLK);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL ovr_restart: got valid=%b, expected 0", bus.tx_valid); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovr_leftover: got %0d, expected 0", exp_q.size()); end
    set_rand_regs();
    push_frame();
    pulse_req();
    @(negedge CLK);
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b, expected 0", ovr); end
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout: got no done, expected done"); end
  endtask

  task automatic test_abort();
    int d0;
    bit ok;
    set_rand_regs();
    push_frame();
    pulse_req();
    d0 = done_cnt;
    repeat (9) @(posedge CLK);
    #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    @(negedge CLK);
    checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: got valid=%b busy=%b, expected 0 0", bus.tx_valid, busy); end
    #1;
    checks++; if (exp_q.size() != NB - 10) begin errors++; $display("FAIL abort_count: got %0d left, expected %0d", exp_q.size(), NB - 10); end
    exp_q.delete();
    repeat (NB) @(negedge CLK);
    #1;
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done: got %0d done pulses, expected 0", done_cnt - d0); end
    set_rand_regs();
    push_frame();
    pulse_req();
    wait_done(60, ok);
    checks++; if (!ok || done_at - c_start !== NB + 1) begin errors++; $display("FAIL abort_restart: got ok=%b N+%0d, expected 1 N+%0d", ok, done_at - c_start, NB + 1); end
  endtask

  task automatic test_req_abort_idle();
    bit ok;
    @(posedge CLK); #1 abort = 1'b1;
    @(posedge CLK); #1 abort = 1'b0;
    @(negedge CLK);
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL idle_abort: got valid=%b, expected 0", bus.tx_valid); end
    set_rand_regs();
    push_frame();
    @(posedge CLK); #1 begin req = 1'b1; abort = 1'b1; end
    @(posedge CLK); #1 begin req = 1'b0; abort = 1'b0; end
    c_start = cyc_cnt;
    wait_done(60, ok);
    checks++; if (!ok || done_at - c_start !== NB + 1) begin errors++; $display("FAIL req_abort: got ok=%b N+%0d, expected 1 N+%0d", ok, done_at - c_start, NB + 1); end
  endtask

  task automatic test_async_reset();
    int d0;
    bit ok;
    set_rand_regs();
    push_frame();
    pulse_req();
    d0 = done_cnt;
    repeat (12) @(posedge CLK);
    #2 nRES = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || ovr !== 1'b0 || bus.tx_data !== 8'h00) begin errors++; $display("FAIL arst_outputs: got valid=%b busy=%b done=%b ovr=%b data=%02h, expected all zero", bus.tx_valid, busy, done, ovr, bus.tx_data); end
    @(negedge CLK); #1;
    checks++; if (exp_q.size() != NB - 12) begin errors++; $display("FAIL arst_count: got %0d left, expected %0d", exp_q.size(), NB - 12); end
    exp_q.delete();
    repeat (2) @(posedge CLK);
    @(negedge CLK) nRES = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    checks++; if (done_cnt != d0 || bus.tx_valid !== 1'b0) begin errors++; $display("FAIL arst_after: got done pulses=%0d valid=%b, expected 0 0", done_cnt - d0, bus.tx_valid); end
    set_rand_regs();
    push_frame();
    pulse_req();
    wait_done(60, ok);
    checks++; if (!ok || done_at - c_start !== NB + 1) begin errors++; $display("FAIL arst_frame: got ok=%b N+%0d, expected 1 N+%0d", ok, done_at - c_start, NB + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    set_rand_regs();
    push_frame();
    pulse_req();
    wait_done(60, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_first: got no done, expected done"); end
    checks++; if (bus.tx_valid !== 1'b0) begin errors++; $display("FAIL b2b_gap: got valid=%b, expected 0", bus.tx_valid); end
    set_rand_regs();
    push_frame();
    req = 1'b1;
    @(posedge CLK); #1 req = 1'b0;
    c_start = cyc_cnt;
    @(negedge CLK);
    checks++; if (bus.tx_valid !== 1'b1 || ovr !== 1'b0) begin errors++; $display("FAIL b2b_start: got valid=%b ovr=%b, expected 1 0", bus.tx_valid, ovr); end
    wait_done(60, ok);
    checks++; if (!ok || done_at - c_start !== NB + 1) begin errors++; $display("FAIL b2b_second: got ok=%b N+%0d, expected 1 N+%0d", ok, done_at - c_start, NB + 1); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d, expected 0", exp_q.size()); end
  endtask

  initial begin
    nRES = 1'b0;
    req = 1'b0;
    abort = 1'b0;
    bus.tx_ready = 1'b1;
    set_regs(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
             16'h0000, 16'h0000, 8'h00, 8'h00);
    test_reset();
    test_boot_frame();
    test_backpressure();
    test_overrun();
    test_abort();
    test_req_abort_idle();
    test_async_reset();
    test_back_to_back();
    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
